cra_sequencer: RTL and testbench

//  Microsequencer (M8541 CRA equivalent) directly upstream of the CRM control store.

---
 rtl/cra_pkg.sv | 31 +++
 rtl/cra_sequencer_if.sv | 35 +++
 rtl/cra_stack.sv | 83 ++++++++
 rtl/cra_sequencer.sv | 80 ++++++++
 tb/tb_cra_sequencer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cra_pkg.sv
// Shared types and dispatch codes for the CRA microsequencer.
package cra_pkg;

    localparam int unsigned CRA_W  = 12;
    localparam int unsigned DISP_W = 5;
    localparam int unsigned NUM_MW = 6;

    typedef logic [0:CRA_W-1] cra_t;

    typedef enum logic [DISP_W-1:0] {
        DISP_NONE   = 5'd0,
        DISP_RETURN = 5'd1,
        DISP_DRAMJ  = 5'd2,
        DISP_MW0    = 5'd3,
        DISP_MW1    = 5'd4,
        DISP_MW2    = 5'd5,
        DISP_MW3    = 5'd6,
        DISP_MW4    = 5'd7,
        DISP_MW5    = 5'd8
    } disp_e;

    // Nibble of the multiway source selected by an MW dispatch code; zero otherwise.
    function automatic logic [0:3] mw_nibble(input logic [0:DISP_W-1] disp,
                                             input logic [0:4*NUM_MW-1] src);
        mw_nibble = '0;
        for (int k = 0; k < NUM_MW; k++) begin
            if (disp == DISP_W'(int'(DISP_MW0) + k)) mw_nibble = src[4*k +: 4];
        end
    endfunction

endpackage

// File: rtl/cra_sequencer_if.sv
// Microword fields, dispatch sources and control-store address bus of the CRA sequencer.
interface cra_sequencer_if #(
    parameter int unsigned NCOND = 64
);
    import cra_pkg::*;

    cra_t             CRAM_J;
    logic [0:5]       CRAM_SKIP;
    logic [0:4]       CRAM_DISP;
    logic             CRAM_CALL;
    logic [0:NCOND-1] skipCond;
    logic [0:23]      dispSrc;
    cra_t             dramJ;
    logic             crStall;
    logic             forceEn;
    cra_t             forceAdr;
    logic             stackClr;
    cra_t             CRADR;
    cra_t             curAdr;
    logic             cramValid;
    logic             stackErr;

    modport master (
        input  CRAM_J, CRAM_SKIP, CRAM_DISP, CRAM_CALL, skipCond, dispSrc, dramJ,
        input  crStall, forceEn, forceAdr, stackClr,
        output CRADR, curAdr, cramValid, stackErr
    );

    modport slave (
        output CRAM_J, CRAM_SKIP, CRAM_DISP, CRAM_CALL, skipCond, dispSrc, dramJ,
        output crStall, forceEn, forceAdr, stackClr,
        input  CRADR, curAdr, cramValid, stackErr
    );

endinterface

// File: rtl/cra_stack.sv
// Circular microsubroutine return stack: overflow overwrites the oldest entry, sp saturates.
module cra_stack import cra_pkg::*; #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic clr,
    input  cra_t din,
    output cra_t top,
    output logic empty,
    output logic full,
    output logic err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = PW + 1;

    cra_t          mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, top_idx, wr_idx;
    logic [SW-1:0] sp_q, sp_d;
    logic          err_q, err_d, wr_en;

    assign top_idx = wp_q - PW'(1);
    assign empty   = (sp_q == '0) | clr;
    assign full    = (sp_q == SW'(DEPTH));
    assign top     = mem_q[top_idx];
    assign err     = err_q;

    always_comb begin
        wp_d   = wp_q;
        sp_d   = sp_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = wp_q;
        if (clr) begin
            wp_d  = '0;
            sp_d  = '0;
            err_d = 1'b0;
            if (push) begin
                wr_en  = 1'b1;
                wr_idx = '0;
                wp_d   = PW'(1);
                sp_d   = SW'(1);
            end
        end else if (push && pop && !empty) begin
            // Popped slot is refilled in place; depth is unchanged.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else begin
            if (pop) begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    wp_d = top_idx;
                    sp_d = sp_q - SW'(1);
                end
            end
            if (push) begin
                wr_en = 1'b1;
                wp_d  = wp_q + PW'(1);
                if (full) err_d = 1'b1;
                else      sp_d  = sp_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wp_q  <= wp_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            if (wr_en) mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/cra_sequencer.sv
// CRA microsequencer: next control-RAM address mux, skip OR, call/return stack, curAdr.
module cra_sequencer import cra_pkg::*; #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned NCOND       = 64
) (
    input logic            eboxClk,
    input logic            eboxReset_n,
    cra_sequencer_if.master bus
);

    logic             valid_q;
    cra_t             cur_q;
    cra_t             dispatched;
    cra_t             cradr;
    logic [0:NCOND-1] cond;
    logic             skip_hit;
    logic             active, push, pop;
    cra_t             stk_top;
    logic             stk_empty, stk_full, stk_err;
    logic             unused_full;

    assign cond        = bus.skipCond;
    assign unused_full = stk_full;

    // Stack traffic only for a valid word that is neither forced nor stalled.
    assign active = valid_q & ~bus.forceEn & ~bus.crStall;
    assign pop    = active & (bus.CRAM_DISP == DISP_RETURN);
    assign push   = active & bus.CRAM_CALL;

    cra_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (eboxClk),
        .rst_n (eboxReset_n),
        .push  (push),
        .pop   (pop),
        .clr   (bus.stackClr),
        .din   (cur_q),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full),
        .err   (stk_err)
    );

    always_comb begin
        dispatched = bus.CRAM_J;
        case (bus.CRAM_DISP)
            DISP_RETURN: dispatched = bus.CRAM_J | (stk_empty ? '0 : stk_top);
            DISP_DRAMJ:  dispatched = bus.CRAM_J | bus.dramJ;
            DISP_MW0, DISP_MW1, DISP_MW2, DISP_MW3, DISP_MW4, DISP_MW5:
                dispatched = bus.CRAM_J | {8'b0, mw_nibble(bus.CRAM_DISP, bus.dispSrc)};
            default: ;
        endcase
    end

    assign skip_hit = (bus.CRAM_SKIP != '0) & cond[bus.CRAM_SKIP];

    always_comb begin
        cradr = dispatched | {11'b0, skip_hit};
        if (!valid_q)         cradr = '0;
        else if (bus.forceEn) cradr = bus.forceAdr;
        else if (bus.crStall) cradr = cur_q;
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            valid_q <= 1'b0;
            cur_q   <= '0;
        end else begin
            valid_q <= 1'b1;
            cur_q   <= cradr;
        end
    end

    assign bus.CRADR     = cradr;
    assign bus.curAdr    = cur_q;
    assign bus.cramValid = valid_q;
    assign bus.stackErr  = stk_err;

endmodule

// File: tb/tb_cra_sequencer.sv
// Bench for cra_sequencer: directed scenarios plus random words against a queue-based model.
module tb_cra_sequencer;
    import cra_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    bit   m_valid;
    cra_t m_cur;
    cra_t m_stk[$];
    bit   m_err;

    cra_sequencer_if #(.NCOND(64)) bus ();

    cra_sequencer #(
        .STACK_DEPTH (DEPTH),
        .NCOND       (64)
    ) dut (
        .eboxClk     (clk),
        .eboxReset_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_valid = 1'b0;
        m_cur   = '0;
        m_stk.delete();
        m_err   = 1'b0;
    endfunction

    function automatic cra_t model_next();
        cra_t a;
        int   d;
        if (!m_valid) return '0;
        if (bus.forceEn) return bus.forceAdr;
        if (bus.crStall) return m_cur;
        d = int'(bus.CRAM_DISP);
        a = bus.CRAM_J;
        if (d == 1) begin
            if (m_stk.size() != 0 && !bus.stackClr) a = a | m_stk[$];
        end else if (d == 2) begin
            a = a | bus.dramJ;
        end else if (d >= 3 && d <= 8) begin
            a = a | {8'h0, bus.dispSrc[4*(d-3) +: 4]};
        end
        if (bus.CRAM_SKIP != 0 && bus.skipCond[bus.CRAM_SKIP]) a = a | 12'd1;
        return a;
    endfunction

    task automatic model_edge(input cra_t nxt);
        bit act, pop, push;
        act  = m_valid && !bus.forceEn && !bus.crStall;
        pop  = act && (int'(bus.CRAM_DISP) == 1);
        push = act && bus.CRAM_CALL;
        if (bus.stackClr) begin
            m_stk.delete();
            m_err = 1'b0;
            if (push) m_stk.push_back(m_cur);
        end else begin
            if (pop) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else void'(m_stk.pop_back());
            end
            if (push) begin
                if (m_stk.size() == DEPTH) begin
                    m_err = 1'b1;
                    void'(m_stk.pop_front());
                end
                m_stk.push_back(m_cur);
            end
        end
        m_cur   = nxt;
        m_valid = 1'b1;
    endtask

    task automatic cycle();
        cra_t nxt;
        nxt = model_next();
        @(posedge clk);
        model_edge(nxt);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.CRAM_J    = '0;
        bus.CRAM_SKIP = '0;
        bus.CRAM_DISP = '0;
        bus.CRAM_CALL = 1'b0;
        bus.skipCond  = '0;
        bus.dispSrc   = '0;
        bus.dramJ     = '0;
        bus.crStall   = 1'b0;
        bus.forceEn   = 1'b0;
        bus.forceAdr  = '0;
        bus.stackClr  = 1'b0;
    endtask

    task automatic word(input cra_t j, input logic [4:0] disp, input logic call);
        idle();
        bus.CRAM_J    = j;
        bus.CRAM_DISP = disp;
        bus.CRAM_CALL = call;
    endtask

    task automatic clear_stack();
        idle();
        bus.stackClr = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.cramValid !== 1'b0 || bus.curAdr !== 12'o0 || bus.stackErr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b cur=%o err=%b expected 0 0 0",
                     bus.cramValid, bus.curAdr, bus.stackErr);
        end
        rst_n = 1'b1;
        word(12'o0100, DISP_NONE, 1'b0);
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0) begin
            miscompares++;
            $display("FAIL reset_cycle0: CRADR=%o expected 0", bus.CRADR);
        end
        cycle();
        #1;
        vectors++;
        if (bus.cramValid !== 1'b1 || bus.CRADR !== 12'o0100) begin
            miscompares++;
            $display("FAIL reset_cycle1: valid=%b CRADR=%o expected 1 0100",
                     bus.cramValid, bus.CRADR);
        end
        cycle();
        vectors++;
        if (bus.curAdr !== 12'o0100) begin
            miscompares++;
            $display("FAIL reset_curadr: curAdr=%o expected 0100", bus.curAdr);
        end
    endtask

    task automatic test_skip();
        word(12'o0200, DISP_NONE, 1'b0);
        bus.CRAM_SKIP   = 6'd5;
        bus.skipCond[5] = 1'b1;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0201) begin
            miscompares++;
            $display("FAIL skip_taken: CRADR=%o expected 0201", bus.CRADR);
        end
        bus.skipCond[5] = 1'b0;
        bus.skipCond[6] = 1'b1;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0200) begin
            miscompares++;
            $display("FAIL skip_not_taken: CRADR=%o expected 0200", bus.CRADR);
        end
        cycle();
    endtask

    task automatic test_dispatch();
        word(12'o1230, DISP_MW2, 1'b0);
        bus.dispSrc = 24'h12A456;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o1232) begin
            miscompares++;
            $display("FAIL disp_mw2: CRADR=%o expected 1232", bus.CRADR);
        end
        bus.CRAM_DISP = DISP_MW5;
        bus.CRAM_J    = 12'o7770;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o7776) begin
            miscompares++;
            $display("FAIL disp_mw5: CRADR=%o expected 7776", bus.CRADR);
        end
        word(12'o4000, DISP_DRAMJ, 1'b0);
        bus.dramJ = 12'o0123;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o4123) begin
            miscompares++;
            $display("FAIL disp_dramj: CRADR=%o expected 4123", bus.CRADR);
        end
        word(12'o0055, 5'd20, 1'b0);
        bus.dramJ   = 12'o7700;
        bus.dispSrc = 24'hFFFFFF;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0055) begin
            miscompares++;
            $display("FAIL disp_undefined: CRADR=%o expected 0055", bus.CRADR);
        end
        cycle();
    endtask

    task automatic test_call_return();
        clear_stack();
        word(12'o0300, DISP_NONE, 1'b0);
        cycle();
        word(12'o0400, DISP_NONE, 1'b1);
        cycle();
        word(12'o0002, DISP_RETURN, 1'b0);
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0302) begin
            miscompares++;
            $display("FAIL call_return: CRADR=%o expected 0302", bus.CRADR);
        end
        cycle();
        word(12'o0005, DISP_RETURN, 1'b0);
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0005) begin
            miscompares++;
            $display("FAIL return_empty: CRADR=%o expected 0005", bus.CRADR);
        end
        cycle();
        vectors++;
        if (bus.stackErr !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_err: stackErr=%b expected 1", bus.stackErr);
        end
        clear_stack();
        vectors++;
        if (bus.stackErr !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_err: stackErr=%b expected 0", bus.stackErr);
        end
    endtask

    task automatic test_back_to_back();
        clear_stack();
        word(12'o0700, DISP_NONE, 1'b0);
        cycle();
        word(12'o0710, DISP_NONE, 1'b1);
        cycle();
        word(12'o0003, DISP_RETURN, 1'b1);
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0703) begin
            miscompares++;
            $display("FAIL callret_same: CRADR=%o expected 0703", bus.CRADR);
        end
        cycle();
        word(12'o0000, DISP_RETURN, 1'b0);
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0710 || bus.stackErr !== 1'b0) begin
            miscompares++;
            $display("FAIL callret_refill: CRADR=%o err=%b expected 0710 0",
                     bus.CRADR, bus.stackErr);
        end
        cycle();
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0000) begin
            miscompares++;
            $display("FAIL callret_depth: CRADR=%o expected 0000", bus.CRADR);
        end
        cycle();
    endtask

    task automatic test_overflow();
        cra_t a;
        clear_stack();
        word(12'o2000, DISP_NONE, 1'b0);
        cycle();
        for (int i = 1; i <= 17; i++) begin
            word(cra_t'(12'o2000 + 8 * i), DISP_NONE, 1'b1);
            cycle();
        end
        vectors++;
        if (bus.stackErr !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_err: stackErr=%b expected 1", bus.stackErr);
        end
        for (int i = 16; i >= 0; i--) begin
            word(12'o0007, DISP_RETURN, 1'b0);
            a = (i == 0) ? 12'o0007 : cra_t'((12'o2000 + 8 * i) | 7);
            #1;
            vectors++;
            if (bus.CRADR !== a) begin
                miscompares++;
                $display("FAIL overflow_pop%0d: CRADR=%o expected %o", 16 - i, bus.CRADR, a);
            end
            cycle();
        end
        vectors++;
        if (bus.stackErr !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: stackErr=%b expected 1", bus.stackErr);
        end
    endtask

    task automatic test_priority();
        clear_stack();
        word(12'o0500, DISP_NONE, 1'b0);
        cycle();
        word(12'o0600, DISP_NONE, 1'b1);
        cycle();
        word(12'o0777, DISP_RETURN, 1'b1);
        bus.forceEn     = 1'b1;
        bus.crStall     = 1'b1;
        bus.forceAdr    = 12'o1000;
        bus.CRAM_SKIP   = 6'd1;
        bus.skipCond[1] = 1'b1;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o1000) begin
            miscompares++;
            $display("FAIL prio_force: CRADR=%o expected 1000", bus.CRADR);
        end
        cycle();
        bus.forceEn = 1'b0;
        #1;
        vectors++;
        if (bus.CRADR !== 12'o1000 || bus.curAdr !== 12'o1000) begin
            miscompares++;
            $display("FAIL prio_stall: CRADR=%o curAdr=%o expected 1000 1000",
                     bus.CRADR, bus.curAdr);
        end
        cycle();
        word(12'o0000, DISP_RETURN, 1'b0);
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0500) begin
            miscompares++;
            $display("FAIL prio_sp_kept: CRADR=%o expected 0500", bus.CRADR);
        end
        cycle();
        vectors++;
        if (bus.stackErr !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_no_err: stackErr=%b expected 0", bus.stackErr);
        end
    endtask

    task automatic test_async_reset();
        clear_stack();
        word(12'o0000, DISP_RETURN, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            word(12'o3000, DISP_NONE, 1'b1);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (bus.curAdr !== 12'o0 || bus.cramValid !== 1'b0 || bus.stackErr !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: cur=%o valid=%b err=%b expected 0 0 0",
                     bus.curAdr, bus.cramValid, bus.stackErr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        word(12'o0011, DISP_RETURN, 1'b0);
        cycle();
        #1;
        vectors++;
        if (bus.CRADR !== 12'o0011) begin
            miscompares++;
            $display("FAIL async_empty: CRADR=%o expected 0011", bus.CRADR);
        end
        cycle();
        vectors++;
        if (bus.stackErr !== 1'b1) begin
            miscompares++;
            $display("FAIL async_sp0: stackErr=%b expected 1", bus.stackErr);
        end
        clear_stack();
    endtask

    task automatic test_random();
        cra_t exp;
        for (int n = 0; n < 600; n++) begin
            idle();
            bus.CRAM_J      = cra_t'($urandom);
            bus.CRAM_SKIP   = 6'($urandom_range(63));
            bus.CRAM_DISP   = 5'($urandom_range(12));
            bus.CRAM_CALL   = ($urandom_range(2) == 0);
            bus.skipCond    = {$urandom, $urandom};
            bus.skipCond[0] = 1'b0;
            bus.dispSrc     = 24'($urandom);
            bus.dramJ       = cra_t'($urandom);
            bus.forceEn     = ($urandom_range(15) == 0);
            bus.crStall     = ($urandom_range(7) == 0);
            bus.forceAdr    = cra_t'($urandom);
            bus.stackClr    = ($urandom_range(40) == 0);
            #1;
            exp = model_next();
            vectors++;
            if (bus.CRADR !== exp) begin
                miscompares++;
                $display("FAIL rand_cradr[%0d]: CRADR=%o expected %o", n, bus.CRADR, exp);
            end
            vectors++;
            if (bus.curAdr !== m_cur || bus.cramValid !== m_valid || bus.stackErr !== m_err) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: cur=%o valid=%b err=%b expected %o %b %b",
                         n, bus.curAdr, bus.cramValid, bus.stackErr, m_cur, m_valid, m_err);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_dispatch();
        test_call_return();
        test_back_to_back();
        test_overflow();
        test_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
